// File: rtl/gate_truth_table_checker_if.sv
// Signal bundle between the truth-table checker and its caller / gate under test.
// The slave side is the checker; the master side is the caller plus the gate.
interface gate_truth_table_checker_if;
  logic       start;
  logic [3:0] expected_tt;
  logic       dut_a;
  logic       dut_b;
  logic       dut_o;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] mismatch_count;
  logic [1:0] fail_index;

  modport master (
    output start, expected_tt, dut_o,
    input  dut_a, dut_b, busy, done, pass, mismatch_count, fail_index
  );

  modport slave (
    input  start, expected_tt, dut_o,
    output dut_a, dut_b, busy, done, pass, mismatch_count, fail_index
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Self-test engine: sweeps all four {a,b} combinations into a 2-input gate and
// compares each settled output against a latched 4-entry expected truth table.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                        clk,
  input logic                        rst_n,
  gate_truth_table_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic [1:0] idx;
  logic [3:0] tt_q;
  logic       dut_a;
  logic       dut_b;
  logic       pass;
  logic [2:0] mismatch_count;
  logic [1:0] fail_index;
  logic       busy;
  logic       done;
  logic       accept;
  logic       sample_edge;
  logic       mismatch;

  assign accept      = (state == IDLE) && bus.start;
  assign sample_edge = (state == RUN) && (settle_cnt == SETTLE_LAST);
  assign mismatch    = bus.dut_o != tt_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (sample_edge && (idx == 2'd3)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Results are updated on each sample edge; pass is decided on the last one so it
  // becomes visible together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt     <= '0;
      idx            <= '0;
      tt_q           <= '0;
      dut_a          <= 1'b0;
      dut_b          <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      fail_index     <= '0;
    end else if (accept) begin
      settle_cnt     <= '0;
      idx            <= '0;
      tt_q           <= bus.expected_tt;
      dut_a          <= 1'b0;
      dut_b          <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      fail_index     <= '0;
    end else if (state == RUN) begin
      if (sample_edge) begin
        settle_cnt <= '0;
        if (mismatch) begin
          mismatch_count <= mismatch_count + 3'd1;
          if (mismatch_count == 3'd0) begin
            fail_index <= idx;
          end
        end
        if (idx == 2'd3) begin
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          pass  <= (mismatch_count == 3'd0) && !mismatch;
        end else begin
          idx            <= idx + 2'd1;
          {dut_a, dut_b} <= idx + 2'd1;
        end
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  assign bus.dut_a          = dut_a;
  assign bus.dut_b          = dut_b;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.mismatch_count = mismatch_count;
  assign bus.fail_index     = fail_index;

endmodule
